pipeline_stage_rv: RTL

- Parametrised, generic pipeline stage register that replaces the hand-written per-stage registers (F/D/E/M/W) with one reusable block.
- Carries an opaque payload bus with a valid/ready handshake and a 2-entry skid buffer, so back-pressure is fully registered and throughput stays at 1 beat/cycle.
- Adds flush (bubble insertion on branch/exception) and a global freeze (`Busy`, e.g. multi-cycle MUL/DIV or cache miss) on top of the plain stall-only stage behaviour.

---
 rtl/pipeline_stage_rv.sv | 119 +++++++++++
 1 files changed

// File: rtl/pipeline_stage_rv.sv
// Generic valid/ready pipeline stage with a 2-entry skid buffer, flush and global freeze (Busy).
// Optional occupancy statistics ports are enabled with `define PIPELINE_STAGE_STATS_EN.
module pipeline_stage_rv #(
  parameter int               DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit               FLUSH_CLR = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              Busy,
  input  logic              Flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef PIPELINE_STAGE_STATS_EN
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       stall_cnt,
  output logic [15:0]       flush_cnt
`else
  output logic [DATA_W-1:0] out_data
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e              state_q, state_d;
  logic [DATA_W-1:0] main_d_q, main_d_d;
  logic [DATA_W-1:0] skid_d_q, skid_d_d;
  logic              main_v, skid_v;
  logic              acc, drn;

  assign main_v = (state_q != EMPTY);
  assign skid_v = (state_q == TWO);

  // in_ready comes only from registered state and RESET, so back-pressure never chains combinationally.
  assign in_ready  = ~skid_v & ~RESET;
  assign out_valid = main_v & ~RESET;
  assign out_data  = RESET ? RESET_VAL : main_d_q;

  assign acc = in_valid & in_ready & ~Busy & ~Flush;
  assign drn = main_v & out_ready & ~Busy;

  always_comb begin
    state_d  = state_q;
    main_d_d = main_d_q;
    skid_d_d = skid_d_q;
    if (Flush) begin
      state_d = EMPTY;
      if (FLUSH_CLR) begin
        main_d_d = RESET_VAL;
        skid_d_d = RESET_VAL;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d  = ONE;
            main_d_d = in_data;
          end
        end
        ONE: begin
          if (acc && drn) begin
            main_d_d = in_data;
          end else if (acc) begin
            state_d  = TWO;
            skid_d_d = in_data;
          end else if (drn) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (drn) begin
            state_d  = ONE;
            main_d_d = skid_d_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= EMPTY;
      main_d_q <= RESET_VAL;
      skid_d_q <= RESET_VAL;
    end else begin
      state_q  <= state_d;
      main_d_q <= main_d_d;
      skid_d_q <= skid_d_d;
    end
  end

`ifdef PIPELINE_STAGE_STATS_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  // Stall count saturates; flush count wraps. Both are frozen while Busy.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!Busy) begin
      if (main_v && !out_ready && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (Flush && main_v)                         flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
